// File: rtl/clic_pkg.sv
// Shared types and helpers for the CLIC interrupt gateway.
package clic_pkg;

   typedef enum logic {
      CLAIM_IDLE = 1'b0,
      CLAIM_ACK  = 1'b1
   } claim_state_e;

   // Claim id width for n sources; never narrower than one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : clic_pkg

// File: rtl/clic_int_gateway_src.sv
// One interrupt source slice: synchroniser, previous-value register, edge
// detect and the pending flop for level or edge trigger mode.
module clic_int_gateway_src
   import clic_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic irq_src_i,
   input  logic le_i,
   input  logic pol_i,
   input  logic sw_set_i,
   input  logic sw_clr_i,
   input  logic claim_hit_i,
   output logic ip_o
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("clic_int_gateway_src: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   s;
   logic                   edge_det;
   logic                   ip_d;

   assign s = sync_q[SYNC_STAGES-1];

   // Detection runs on the raw synchronised value, so a polarity change alone
   // can never fabricate an edge.
   assign edge_det = pol_i ? (~s & prev_q) : (s & ~prev_q);

   always_comb begin
      // NOTE: default first so every path assigns ip_d and no latch is inferred.
      ip_d = ip_o;
      if (!le_i) begin
         ip_d = s ^ pol_i;
      end else if (edge_det || sw_set_i) begin
         ip_d = 1'b1;
      end else if (claim_hit_i || sw_clr_i) begin
         ip_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!rst_ni) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         ip_o   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_src_i};
         prev_q <= s;
         ip_o   <= ip_d;
      end
   end

endmodule : clic_int_gateway_src

// File: rtl/clic_int_gateway.sv
// CLIC interrupt gateway: per-source trigger handling plus the claim handshake
// that clears edge-mode pending bits.
module clic_int_gateway
   import clic_pkg::*;
#(
   parameter  int N_SOURCE    = 32,
   parameter  int SYNC_STAGES = 2,
   localparam int IDW         = id_width(N_SOURCE)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic [N_SOURCE-1:0] irq_src_i,
   input  logic [N_SOURCE-1:0] le_i,
   input  logic [N_SOURCE-1:0] pol_i,
   input  logic [N_SOURCE-1:0] sw_set_i,
   input  logic [N_SOURCE-1:0] sw_clr_i,
   input  logic                claim_valid_i,
   input  logic [IDW-1:0]      claim_id_i,
   output logic                claim_ready_o,
   output logic                claim_ack_o,
   output logic [IDW-1:0]      claim_ack_id_o,
   output logic                claim_ack_edge_o,
   output logic [N_SOURCE-1:0] ip_o
);

   claim_state_e        state_q, state_d;
   logic                accept;
   logic                id_in_range;
   logic [N_SOURCE-1:0] claim_hit;
   logic                edge_flag;

   assign accept      = (state_q == CLAIM_IDLE) && claim_valid_i;
   assign id_in_range = int'(claim_id_i) < N_SOURCE;

   for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
      assign claim_hit[i] = accept && id_in_range && (claim_id_i == IDW'(i));

      clic_int_gateway_src #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_src (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .irq_src_i   (irq_src_i[i]),
         .le_i        (le_i[i]),
         .pol_i       (pol_i[i]),
         .sw_set_i    (sw_set_i[i]),
         .sw_clr_i    (sw_clr_i[i]),
         .claim_hit_i (claim_hit[i]),
         .ip_o        (ip_o[i])
      );
   end

   // Out-of-range ids hit nothing, so the flag reads 0 for them.
   assign edge_flag = |(claim_hit & le_i & ip_o);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q          <= CLAIM_IDLE;
         claim_ack_id_o   <= '0;
         claim_ack_edge_o <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            claim_ack_id_o   <= claim_id_i;
            claim_ack_edge_o <= edge_flag;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         CLAIM_IDLE: if (claim_valid_i) state_d = CLAIM_ACK;
         CLAIM_ACK:  state_d = CLAIM_IDLE;
         default:    state_d = CLAIM_IDLE;
      endcase
   end

   always_comb begin
      claim_ready_o = 1'b0;
      claim_ack_o   = 1'b0;
      unique case (state_q)
         CLAIM_IDLE: claim_ready_o = 1'b1;
         CLAIM_ACK:  claim_ack_o   = 1'b1;
         default:    claim_ready_o = 1'b1;
      endcase
   end

endmodule : clic_int_gateway

// File: tb/tb_clic_int_gateway.sv
// Self-checking bench for clic_int_gateway: directed scenarios plus random
// traffic, all compared against a sample-history reference model.
module tb_clic_int_gateway;

   localparam int N   = 32;
   localparam int SS  = 2;
   localparam int IDW = 5;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   irq_src = '0, le = '0, pol = '0, sw_set = '0, sw_clr = '0;
   logic           claim_valid = 1'b0;
   logic [IDW-1:0] claim_id = '0;
   logic           claim_ready, claim_ack, claim_ack_edge;
   logic [IDW-1:0] claim_ack_id;
   logic [N-1:0]   ip;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: history of sampled lines, pending vector, pending ack.
   logic [N-1:0]   m_hist [SS+1];
   logic [N-1:0]   m_ip;
   logic           m_ack;
   logic [IDW-1:0] m_ack_id;
   logic           m_ack_edge;

   always #5 clk = ~clk;

   clic_int_gateway #(
      .N_SOURCE    (N),
      .SYNC_STAGES (SS)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rst_n),
      .irq_src_i        (irq_src),
      .le_i             (le),
      .pol_i            (pol),
      .sw_set_i         (sw_set),
      .sw_clr_i         (sw_clr),
      .claim_valid_i    (claim_valid),
      .claim_id_i       (claim_id),
      .claim_ready_o    (claim_ready),
      .claim_ack_o      (claim_ack),
      .claim_ack_id_o   (claim_ack_id),
      .claim_ack_edge_o (claim_ack_edge),
      .ip_o             (ip)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j <= SS; j++) m_hist[j] = '0;
      m_ip       = '0;
      m_ack      = 1'b0;
      m_ack_id   = '0;
      m_ack_edge = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs driven this cycle.
   task automatic model_edge();
      logic [N-1:0] s, p, nip;
      logic         acc;
      s   = m_hist[SS-1];
      p   = m_hist[SS];
      acc = !m_ack && claim_valid;
      for (int i = 0; i < N; i++) begin
         logic ev;
         ev = pol[i] ? (!s[i] && p[i]) : (s[i] && !p[i]);
         if (!le[i])                                   nip[i] = s[i] ^ pol[i];
         else if (ev || sw_set[i])                     nip[i] = 1'b1;
         else if ((acc && claim_id == i) || sw_clr[i]) nip[i] = 1'b0;
         else                                          nip[i] = m_ip[i];
      end
      if (acc) begin
         m_ack_id   = claim_id;
         m_ack_edge = le[claim_id] & m_ip[claim_id];
      end
      m_ack = acc;
      m_ip  = nip;
      for (int j = SS; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = irq_src;
   endtask

   task automatic compare_all();
      check("ip", 64'(ip), 64'(m_ip));
      check("ready", 64'(claim_ready), 64'(!m_ack));
      check("ack", 64'(claim_ack), 64'(m_ack));
      if (m_ack) begin
         check("ack_id", 64'(claim_ack_id), 64'(m_ack_id));
         check("ack_edge", 64'(claim_ack_edge), 64'(m_ack_edge));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int far_id;
      logic [7:0] far_id8;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset values
      check("rst_ip", 64'(ip), 64'h0);
      check("rst_ready", 64'(claim_ready), 64'h1);
      check("rst_ack", 64'(claim_ack), 64'h0);
      check("rst_ack_id", 64'(claim_ack_id), 64'h0);
      check("rst_ack_edge", 64'(claim_ack_edge), 64'h0);

      // Level, active-low on source 5
      irq_src[5] = 1'b1; pol[5] = 1'b1;
      ticks(4);
      check("lvl5_idle", 64'(ip[5]), 64'h0);
      irq_src[5] = 1'b0;
      ticks(2);
      check("lvl5_not_yet", 64'(ip[5]), 64'h0);
      tick();
      check("lvl5_asserted", 64'(ip[5]), 64'h1);
      claim_valid = 1'b1; claim_id = 5'd5;
      tick();
      claim_valid = 1'b0;
      check("lvl5_ack_edge", 64'(claim_ack_edge), 64'h0);
      check("lvl5_held", 64'(ip[5]), 64'h1);
      irq_src[5] = 1'b1;
      ticks(2);
      check("lvl5_rel_wait", 64'(ip[5]), 64'h1);
      tick();
      check("lvl5_released", 64'(ip[5]), 64'h0);

      // Rising edge on source 3
      le[3] = 1'b1;
      tick();
      irq_src[3] = 1'b1;
      tick();
      irq_src[3] = 1'b0;
      ticks(4);
      check("edge3_pending", 64'(ip[3]), 64'h1);
      claim_valid = 1'b1; claim_id = 5'd3;
      tick();
      claim_valid = 1'b0;
      check("edge3_ack", 64'(claim_ack), 64'h1);
      check("edge3_ack_id", 64'(claim_ack_id), 64'd3);
      check("edge3_ack_edge", 64'(claim_ack_edge), 64'h1);
      check("edge3_cleared", 64'(ip[3]), 64'h0);

      // New edge landing on the claim-accept edge
      tick();
      irq_src[3] = 1'b1;
      tick();
      irq_src[3] = 1'b0;
      ticks(3);
      irq_src[3] = 1'b1;
      tick();
      irq_src[3] = 1'b0;
      tick();
      claim_valid = 1'b1; claim_id = 5'd3;
      tick();
      claim_valid = 1'b0;
      check("coinc_ip3", 64'(ip[3]), 64'h1);
      check("coinc_ack_edge", 64'(claim_ack_edge), 64'h1);
      tick();

      // Software set/clear on source 7
      le[7] = 1'b1;
      tick();
      sw_set[7] = 1'b1;
      tick();
      sw_set[7] = 1'b0;
      check("sw_set7", 64'(ip[7]), 64'h1);
      sw_set[7] = 1'b1; sw_clr[7] = 1'b1;
      tick();
      sw_set[7] = 1'b0; sw_clr[7] = 1'b0;
      check("sw_both7", 64'(ip[7]), 64'h1);
      sw_clr[7] = 1'b1;
      tick();
      sw_clr[7] = 1'b0;
      check("sw_clr7", 64'(ip[7]), 64'h0);
      le[7] = 1'b0;
      tick();
      sw_set[7] = 1'b1;
      tick();
      sw_set[7] = 1'b0;
      check("sw_set7_level", 64'(ip[7]), 64'h0);

      // Back-to-back claims
      claim_valid = 1'b1;
      claim_id = 5'd1; check("b2b_rdy0", 64'(claim_ready), 64'h1); tick();
      check("b2b_ack0", 64'(claim_ack_id), 64'd1);
      claim_id = 5'd1; check("b2b_rdy1", 64'(claim_ready), 64'h0); tick();
      claim_id = 5'd2; check("b2b_rdy2", 64'(claim_ready), 64'h1); tick();
      check("b2b_ack2", 64'(claim_ack_id), 64'd2);
      claim_id = 5'd2; check("b2b_rdy3", 64'(claim_ready), 64'h0); tick();
      claim_valid = 1'b0;

      // Id 40 wraps to the port width; source 8 idle, so nothing changes
      far_id  = 40;
      far_id8 = far_id[7:0];
      claim_id = far_id8[IDW-1:0];
      claim_valid = 1'b1;
      tick();
      claim_valid = 1'b0;
      check("far_ack_id", 64'(claim_ack_id), 64'd8);
      check("far_ack_edge", 64'(claim_ack_edge), 64'h0);
      check("far_ip8", 64'(ip[8]), 64'h0);

      // Reset asserted during an ACK cycle
      sw_set[3] = 1'b1;
      tick();
      sw_set[3] = 1'b0;
      claim_valid = 1'b1; claim_id = 5'd9;
      tick();
      claim_valid = 1'b0;
      check("pre_rst_ack", 64'(claim_ack), 64'h1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ack", 64'(claim_ack), 64'h0);
      check("mid_rst_ip", 64'(ip), 64'h0);
      check("mid_rst_ready", 64'(claim_ready), 64'h1);
      do_reset();
      irq_src = '0; le = '0; pol = '0;
      tick();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         irq_src     = irq_src ^ (N'($urandom) & N'($urandom) & N'($urandom));
         if ($urandom_range(63) == 0) le  = N'($urandom);
         if ($urandom_range(63) == 0) pol = N'($urandom);
         sw_set      = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
         sw_clr      = N'($urandom) & N'($urandom) & N'($urandom) & N'($urandom);
         claim_valid = 1'($urandom_range(1));
         claim_id    = IDW'($urandom_range(N-1));
         tick();
      end
      sw_set = '0; sw_clr = '0; claim_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_clic_int_gateway
